dmem_stage: RTL and testbench

// Data-memory block for the memory stage of the 5-stage MIPS pipeline.
// - Consumes the stage's address (aluoutm), store data (writedatam) and read/write strobes.
// - Returns load data (rdm) to the M/W pipeline register.
// - Models a multi-cycle RAM: drives stallm to the hazard unit, which freezes F/D/E/M while an access is in flight.

---
 rtl/dmem_stage.sv | 80 ++++++++
 tb/tb_dmem_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmem_stage.sv
// dmem_stage: multi-cycle data RAM for the MIPS memory stage, stalling the pipeline while an access is in flight.
// Optional memory-mapped output register enabled by defining DMEM_MMIO_EN.
module dmem_stage #(
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] MMIO_ADDR = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadm,
  input  logic        memwritem,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  output logic [31:0] rdm,
  output logic        stallm,
  output logic        err
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdm_q, rdm_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic          req, complete, aligned, is_mmio, ram_we;
  logic [31:0]   load_val;
  logic          unused_ok;
  assign req       = memreadm | memwritem;
  assign idx       = aluoutm[AW+1:2];
  assign aligned   = aluoutm[1:0] == 2'b00;
  assign complete  = (state_q == BUSY) && (cnt_q == '0);
  assign unused_ok = ^{aluoutm, MMIO_ADDR};
`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_q, mmio_d;
  assign is_mmio  = aluoutm == MMIO_ADDR;
  assign load_val = !aligned ? 32'h0 : is_mmio ? mmio_q : mem_q[idx];
  assign mmio_d   = (complete && memwritem && is_mmio) ? writedatam : mmio_q;
  assign mmio_out = mmio_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) mmio_q <= '0;
    else        mmio_q <= mmio_d;
`else
  assign is_mmio  = 1'b0;
  assign load_val = aligned ? mem_q[idx] : 32'h0;
`endif
  assign ram_we = complete && memwritem && aligned && !is_mmio;
  // Gating with reset drops the freeze the instant reset asserts, even mid-access.
  assign stallm = reset && ((state_q == IDLE) ? req : (state_q == BUSY));
  assign rdm    = rdm_q;
  assign err    = err_q;
  always_comb begin
    state_d = (state_q == IDLE) ? (req ? BUSY : IDLE) :
              (state_q == BUSY) ? ((cnt_q == '0) ? DONE : BUSY) : IDLE;
    cnt_d   = (state_q == IDLE && req) ? CW'(LATENCY - 1) :
              (state_q == BUSY && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    rdm_d   = (complete && memreadm) ? load_val : rdm_q;
    err_d   = err_q | (complete && !aligned);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdm_q   <= rdm_d;
      err_q   <= err_d;
    end
  // RAM contents survive reset; the load path above reads the pre-write word.
  always_ff @(posedge clk)
    if (ram_we) mem_q[idx] <= writedatam;
endmodule

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: directed and random load/store checks of dmem_stage against a word-array reference model.
module tb_dmem_stage;
  logic        clk = 0, reset = 1, memreadm = 0, memwritem = 0;
  logic [31:0] aluoutm = 0, writedatam = 0, rdm;
  logic        stallm, err;
`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_out;
`endif
  int          n_chk = 0, n_fail = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] ref_rdm = 0, ref_mmio = 0, saved;
  logic        ref_err = 0;

  dmem_stage #(.DEPTH(64), .LATENCY(2), .MMIO_ADDR(32'hFFFF_FFFC)) dut (
    .clk(clk), .reset(reset), .memreadm(memreadm), .memwritem(memwritem),
    .aluoutm(aluoutm), .writedatam(writedatam), .rdm(rdm), .stallm(stallm), .err(err)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [5:0] i;
    i = a[7:2];
`ifdef DMEM_MMIO_EN
    if (a == 32'hFFFF_FFFC) begin
      if (rd) ref_rdm = ref_mmio;
      if (wr) ref_mmio = d;
      return;
    end
`endif
    if (rd) ref_rdm = (a[1:0] == 2'b00) ? ref_mem[i] : 32'h0;
    if (wr && a[1:0] == 2'b00) ref_mem[i] = d;
    if (a[1:0] != 2'b00) ref_err = 1'b1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    memreadm = rd; memwritem = wr; aluoutm = a; writedatam = d;
    #1;
    n = 0;
    while (stallm === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    model(rd, wr, a, d);
    check("stall_cycles", n, 3);
    check("rdm", rdm, ref_rdm);
    check("err", {31'b0, err}, {31'b0, ref_err});
`ifdef DMEM_MMIO_EN
    check("mmio_out", mmio_out, ref_mmio);
`endif
    @(posedge clk);
    #1;
    memreadm = 0; memwritem = 0;
  endtask

  initial begin
    // reset held with a store pending
    memwritem = 1; aluoutm = 32'h10; writedatam = 32'hFFFF_0000;
    #1 reset = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rdm", rdm, 0);
    check("rst_stall", {31'b0, stallm}, 0);
    check("rst_err", {31'b0, err}, 0);
    memwritem = 0;
    @(negedge clk) reset = 1;
    for (int i = 0; i < 64; i++) op(0, 1, i * 4, $urandom);
    op(0, 1, 32'h10, 32'hDEAD_BEEF);
    op(1, 0, 32'h10, 0);
    check("lw_10", rdm, 32'hDEAD_BEEF);
    op(1, 0, 32'h110, 0);
    check("lw_alias_110", rdm, 32'hDEAD_BEEF);
    op(0, 1, 32'h13, 32'h1);
    check("misaligned_err", {31'b0, err}, 1);
    op(1, 0, 32'h10, 0);
    check("lw_10_after_mis", rdm, 32'hDEAD_BEEF);
    check("err_sticky", {31'b0, err}, 1);
    // reset during the first BUSY cycle abandons the store
    saved = ref_mem[8];
    @(negedge clk);
    memwritem = 1; aluoutm = 32'h20; writedatam = 32'h55;
    @(posedge clk);
    #1 reset = 0;
    #1;
    check("midrst_stall", {31'b0, stallm}, 0);
    check("midrst_err", {31'b0, err}, 0);
    check("midrst_rdm", rdm, 0);
    memwritem = 0; ref_rdm = 0; ref_err = 0;
    @(negedge clk);
    @(negedge clk) reset = 1;
    op(1, 0, 32'h20, 0);
    check("lw_20_old", rdm, saved);
    op(0, 1, 32'hFFFF_FFFC, 32'h5A);
    saved = ref_mem[63];
    op(1, 0, 32'hFC, 0);
`ifdef DMEM_MMIO_EN
    check("mmio_reg", mmio_out, 32'h5A);
    check("lw_fc_ram", rdm, saved);
`else
    check("lw_fc_alias", rdm, 32'h5A);
`endif
    op(1, 1, 32'h40, 32'h1234_5678);
    saved = ref_mem[16];
    check("rw_new_word", saved, 32'h1234_5678);
    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      logic        rd, wr;
      a = $urandom;
      if ($urandom_range(7) != 0) a[1:0] = 2'b00;
      rd = 1'($urandom_range(1));
      wr = rd ? 1'($urandom_range(1)) : 1'b1;
      op(rd, wr, a, $urandom);
    end
    // reset held with a store pending must not write RAM
    saved = ref_mem[4];
    @(negedge clk);
    reset = 0; memwritem = 1; aluoutm = 32'h10; writedatam = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    #1;
    check("rst2_rdm", rdm, 0);
    check("rst2_stall", {31'b0, stallm}, 0);
    check("rst2_err", {31'b0, err}, 0);
    memwritem = 0; ref_rdm = 0; ref_err = 0;
`ifdef DMEM_MMIO_EN
    ref_mmio = 0;
`endif
    @(negedge clk) reset = 1;
    op(1, 0, 32'h10, 0);
    check("rst2_nowrite", rdm, saved);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
